// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: FSM encoding and default frame.
// No logic, no latency.
// Imported by seq_generator and the bench.
package seq_pkg;

  // Generator FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP_S = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Reference frame, matching the 0110 detector used downstream
  localparam logic [3:0] DEFAULT_PATTERN = 4'b0110;

endpackage

// File: rtl/seq_piso.sv
// Loadable parallel-in serial-out shift register, MSB first, ones shifted in behind.
// q shows d[WIDTH-1] the cycle after load; each shift_en advances one bit.
// load wins over shift_en; no backpressure.
module seq_piso #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  logic [WIDTH-1:0] r_sr;

  // Shift register resets and refills with ones so an idle line reads high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '1;
    end else if (load) begin
      r_sr <= d;
    end else if (shift_en) begin
      r_sr <= {r_sr[WIDTH-2:0], 1'b1};
    end
  end

  assign q = r_sr[WIDTH-1];

endmodule

// File: rtl/seq_generator.sv
// Sends a captured WIDTH-bit pattern reps times, MSB first, with GAP idle bits between frames.
// First bit appears the cycle after an accepted start; done pulses the cycle after the final bit.
// start is ignored unless IDLE with non-zero reps; there is no output backpressure.
module seq_generator
  import seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int              BIT_W    = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [3:0]      GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

  state_t           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_frames;
  logic [3:0]       r_gap_cnt;

  logic             w_accept;
  logic             w_last_bit;
  logic             w_last_frame;
  logic             w_gap_end;
  logic             w_reload;
  logic             w_shift;
  logic [WIDTH-1:0] w_load_dat;

  // Shift-register control: load on accept or at each frame boundary, otherwise shift while sending
  always_comb begin
    w_accept     = (r_state == IDLE) && start && (reps != '0);
    w_last_bit   = (r_state == SHIFT) && (r_bit_cnt == BIT_LAST);
    w_last_frame = (r_frames == CNT_W'(1));
    w_gap_end    = (r_state == GAP_S) && (r_gap_cnt == GAP_LAST);
    w_reload     = w_accept || w_gap_end || (w_last_bit && !w_last_frame && (GAP == 0));
    w_shift      = (r_state == SHIFT) && !w_reload;
    w_load_dat   = w_accept ? pattern : r_pat;
  end

  // The serial line is the shift register MSB itself, so x is a flop output
  seq_piso #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (w_reload),
    .shift_en (w_shift),
    .d        (w_load_dat),
    .q        (x)
  );

  // Frame sequencing FSM with registered x_valid/busy/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pat     <= '0;
      r_bit_cnt <= '0;
      r_frames  <= '0;
      r_gap_cnt <= '0;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (w_accept) begin
            r_state   <= SHIFT;
            r_pat     <= pattern;
            r_frames  <= reps;
            r_bit_cnt <= '0;
            x_valid   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_last_bit) begin
            r_frames  <= r_frames - CNT_W'(1);
            r_bit_cnt <= '0;
            if (w_last_frame) begin
              // Final frame goes straight to DONE, so the counter never wraps
              r_state <= DONE;
              x_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (GAP == 0) begin
              r_state <= SHIFT;
            end else begin
              r_state   <= GAP_S;
              r_gap_cnt <= '0;
              x_valid   <= 1'b0;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end
        end
        GAP_S: begin
          if (w_gap_end) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
            x_valid   <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        DONE: begin
          // start is deliberately not sampled here
          r_state <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: GAP=1 instance for framing checks, GAP=0 instance for loopback.
module tb_seq_generator;
  import seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       start,   start_g0;
  logic [3:0] pattern, pattern_g0;
  logic [3:0] reps,    reps_g0;
  logic       x,  x_valid,  busy,  done;
  logic       x0, x_valid0, busy0, done0;

  int n_checks = 0;
  int n_errors = 0;

  seq_generator #(.WIDTH(4), .CNT_W(4), .GAP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  seq_generator #(.WIDTH(4), .CNT_W(4), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .start(start_g0), .pattern(pattern_g0), .reps(reps_g0),
    .x(x0), .x_valid(x_valid0), .busy(busy0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance into the next cycle; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {x, x_valid, busy, done};
  endfunction

  // {x, x_valid, busy, done} per cycle
  logic [3:0] exp1 [1:6];
  logic [3:0] exp2 [1:11];

  initial begin
    logic [3:0] hist;
    int zcnt, bcnt, dcnt, dcyc;

    exp1 = '{4'b0110, 4'b1110, 4'b1110, 4'b0110, 4'b1001, 4'b1000};
    exp2 = '{4'b0110, 4'b1110, 4'b1110, 4'b0110, 4'b1010,
             4'b0110, 4'b1110, 4'b1110, 4'b0110, 4'b1001, 4'b1000};

    rst = 1'b1; start = 1'b0; pattern = '0; reps = '0;
    start_g0 = 1'b0; pattern_g0 = '0; reps_g0 = '0;
    tick(); tick();
    chk("reset_outs", outs(), 4'b1000);
    chk("reset_outs_g0", {x0, x_valid0, busy0, done0}, 4'b1000);

    // Single frame, start in the first cycle after reset release
    rst = 1'b0;
    pattern = DEFAULT_PATTERN; reps = 4'd1; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("one_frame_c%0d", c), outs(), exp1[c]);
    end

    // Two frames with one gap bit
    pattern = 4'b0110; reps = 4'd2; start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("two_frame_c%0d", c), outs(), exp2[c]);
    end

    // Start and input changes while busy are ignored
    pattern = 4'b1011; reps = 4'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("busy_ign_c1", outs(), 4'b1110);
    tick();
    start = 1'b1; pattern = 4'b0000; reps = 4'd3;
    chk("busy_ign_c2", outs(), 4'b0110);
    tick(); start = 1'b0;
    chk("busy_ign_c3", outs(), 4'b1110);
    tick();
    chk("busy_ign_c4", outs(), 4'b1110);
    // Start raised during DONE must wait for the following IDLE cycle
    pattern = 4'b0000; reps = 4'd1; start = 1'b1;
    tick();
    chk("busy_ign_done", outs(), 4'b1001);
    tick();
    chk("done_start_idle", outs(), 4'b1000);
    tick(); start = 1'b0;
    chk("done_start_late", outs(), 4'b0110);
    tick(); tick(); tick();
    chk("late_frame_c4", outs(), 4'b0110);
    tick();
    chk("late_frame_done", outs(), 4'b1001);
    tick();

    // reps == 0 never starts anything
    reps = 4'd0; pattern = 4'b0000; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("reps0_c%0d", c), outs(), 4'b1000);
    end
    start = 1'b0;

    // Reset mid-frame acts immediately, then a start right after release is honoured
    pattern = 4'b0000; reps = 4'd2; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("pre_rst_c3", outs(), 4'b0110);
    rst = 1'b1;
    #1;
    chk("async_rst", outs(), 4'b1000);
    tick();
    chk("rst_held", outs(), 4'b1000);
    pattern = 4'b0111; reps = 4'd1; start = 1'b1;
    rst = 1'b0;
    tick(); start = 1'b0;
    chk("post_rst_c1", outs(), 4'b0110);
    tick(); tick(); tick();
    chk("post_rst_c4", outs(), 4'b1110);
    tick();
    chk("post_rst_done", outs(), 4'b1001);
    tick();

    // Loopback of GAP=0 stream into an overlapping 0110 detector
    hist = 4'b1111; zcnt = 0; bcnt = 0; dcnt = 0; dcyc = 0;
    pattern_g0 = DEFAULT_PATTERN; reps_g0 = 4'd3; start_g0 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start_g0 = 1'b0;
      if (c == 5) chk("g0_back_to_back", {x0, x_valid0}, 2'b01);
      if (x_valid0) begin
        hist = {hist[2:0], x0};
        if (hist == 4'b0110) zcnt++;
      end
      if (busy0) bcnt++;
      if (done0) begin
        dcnt++;
        dcyc = c;
      end
    end
    chk("loop_z_pulses", zcnt, 3);
    chk("loop_busy_len", bcnt, 12);
    chk("loop_done_cnt", dcnt, 1);
    chk("loop_done_cyc", dcyc, 13);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_generator.md
SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 4, width of the repeat-count input.
REQ-003 SHALL have parameter GAP, default 1, idle bit-times between repeated frames (legal 0..15).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, request to begin a transmission; sampled only in IDLE.
REQ-007 SHALL have port pattern, input, WIDTH, frame to send, MSB first; captured on accepted start.
REQ-008 SHALL have port reps, input, CNT_W, number of frames to send; captured on accepted start.
REQ-009 SHALL have port x, output, 1, serial line; idles high.
REQ-010 SHALL have port x_valid, output, 1, high when x carries a pattern bit.
REQ-011 SHALL have port busy, output, 1, high while a transmission is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when a transmission completes.

Function
REQ-013 SHALL drive all outputs from registers; no combinational path from any input to any output.
REQ-014 SHALL use states IDLE, SHIFT, GAP_S, DONE.
REQ-015 SHALL accept start only when in IDLE with reps != 0; accepted start in cycle N gives x = pattern[WIDTH-1] with x_valid=1 and busy=1 in cycle N+1.
REQ-016 SHALL ignore start when reps == 0: remain IDLE, no busy, no done.
REQ-017 SHALL ignore start while busy; pattern/reps changes after capture SHALL have no effect.
REQ-018 SHALL emit the captured pattern in SHIFT, one bit per cycle, MSB first, for exactly WIDTH cycles.
REQ-019 SHALL, after each frame except the last, enter GAP_S for GAP cycles with x=1, x_valid=0, busy=1; with GAP=0, the next frame's MSB SHALL immediately follow the previous LSB.
REQ-020 SHALL decrement a frame counter at the end of each frame; counter wraps are impossible because the last frame leads directly to DONE.
REQ-021 SHALL, in the cycle after the final LSB, be in DONE: done=1, busy=0, x=1, x_valid=0; then return to IDLE next cycle.
REQ-022 SHALL accept a start asserted during the DONE cycle is NOT accepted; the earliest accepted start is in the first IDLE cycle after DONE.
REQ-023 SHALL produce total busy length = reps*WIDTH + (reps-1)*GAP cycles.

Reset
REQ-024 SHALL, on rst assertion at any time including mid-frame, immediately force state IDLE, x=1, x_valid=0, busy=0, done=0, clearing shift register and counters; no done pulse for an aborted transmission.
REQ-025 SHALL honour start in the first rising clk edge after rst deasserts.

Structure
REQ-026 SHALL place state encodings and the constant DEFAULT_PATTERN = 4'b0110 in shared package seq_pkg.
REQ-027 SHALL instantiate one sub-module seq_piso: a loadable, WIDTH-parameterised parallel-in serial-out shift register (load, shift_en, q = MSB).
REQ-028 SHALL keep bit counter and frame counter in seq_generator.

Verification
REQ-029 SHALL check that pattern=4'b0110, reps=1, start in cycle 0 gives x=0,1,1,0 with x_valid=1 in cycles 1-4, and done=1 in cycle 5.
REQ-030 SHALL check that pattern=0110, reps=2, GAP=1 gives x=0,1,1,0,1,0,1,1,0 in cycles 1-9 (x_valid low in cycle 5), and done in cycle 10.
REQ-031 SHALL check that rst asserted in cycle 3 of a frame gives x=1, busy=0, and x_valid=0 asynchronously, with no done pulse.
REQ-032 SHALL check that start pulsed in cycle 2 of a busy transmission, and start with reps=0 in IDLE, each cause no change to the output sequence.
REQ-033 SHALL check that, in loopback into the team's 0110 overlapping detector with reps=3, GAP=0, the detector z pulses exactly 3 times.
